// File: rtl/sec_an_decoder_ctrl.sv
// Sequential single-error-correcting decoder for the AN code (A = 1939, 8-bit data).
// Bit-serial remainder, signed error-location lookup, correction, then restoring division.
module sec_an_decoder_ctrl #(
  parameter int A     = 1939,
  parameter int NBITS = 19,
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data,
  output logic [5:0]       out_loc,
  output logic             out_corr,
  output logic             out_uncorr
);

  localparam int XW = NBITS + 2;
  localparam int RW = $clog2(A) + 1;
  localparam int CW = $clog2(NBITS);
  localparam int IW = $clog2(DBITS);
  localparam logic [RW-1:0] AR   = RW'(A);
  localparam logic [XW-1:0] AX   = XW'(A);
  localparam logic [XW-1:0] XMAX = XW'(((1 << DBITS) - 1) * A);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds its data stable from valid rising until that edge.
  typedef enum logic [2:0] {IDLE, MOD, LOOKUP, CORR, DIV, DONE} state_t;

  state_t state, nstate;

  logic [NBITS-1:0] x;
  logic [RW-1:0]    r;
  logic [CW-1:0]    cnt;
  logic [5:0]       loc;
  logic [XW-1:0]    rem;
  logic [DBITS-1:0] q;
  logic [IW-1:0]    i;
  logic             corr, uncorr;

  logic [RW-1:0]    r_shift, r_next, p, p2;
  logic [5:0]       lk, mag;
  logic [XW-1:0]    delta, xc, div_d;
  logic             in_range, corr_c, uncorr_c, div_hit;
  logic [DBITS-1:0] q_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nstate = MOD;
      end
      MOD:    if (cnt == '0) nstate = LOOKUP;
      LOOKUP: nstate = CORR;
      CORR:   nstate = DIV;
      DIV:    if (i == '0) nstate = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // 2r + bit stays below 2A, so one conditional subtract keeps r reduced.
  always_comb begin
    r_shift = {r[RW-2:0], x[cnt]};
    r_next  = (r_shift >= AR) ? r_shift - AR : r_shift;
  end

  // Walk 2^(k-1) mod A; a remainder equal to it (or to its negation) names the bit in error.
  always_comb begin
    lk = '0;
    p  = RW'(1);
    p2 = '0;
    for (int k = 1; k <= NBITS; k++) begin
      if (r == p)           lk = 6'(k);
      else if (r == AR - p) lk = 6'(-k);
      p2 = {p[RW-2:0], 1'b0};
      p  = (p2 >= AR) ? p2 - AR : p2;
    end
  end

  // Correction in two's complement so an over-correction below zero is detectable.
  always_comb begin
    mag      = loc[5] ? (~loc + 6'd1) : loc;
    delta    = (loc == '0) ? '0 : (XW'(1) << (mag - 6'd1));
    xc       = loc[5] ? XW'(x) + delta : XW'(x) - delta;
    in_range = !xc[XW-1] && (xc <= XMAX);
    corr_c   = (loc != '0) && in_range;
    uncorr_c = ((r != '0) && (loc == '0)) || !in_range;
  end

  always_comb begin
    div_d     = AX << i;
    div_hit   = (rem >= div_d);
    q_next    = q;
    q_next[i] = div_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      r          <= '0;
      cnt        <= '0;
      loc        <= '0;
      rem        <= '0;
      q          <= '0;
      i          <= '0;
      corr       <= 1'b0;
      uncorr     <= 1'b0;
      out_data   <= '0;
      out_loc    <= '0;
      out_corr   <= 1'b0;
      out_uncorr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x   <= in_code;
          r   <= '0;
          cnt <= CW'(NBITS - 1);
        end
        MOD: begin
          r   <= r_next;
          cnt <= cnt - 1'b1;
        end
        LOOKUP: loc <= lk;
        CORR: begin
          rem    <= xc;
          corr   <= corr_c;
          uncorr <= uncorr_c;
          q      <= '0;
          i      <= IW'(DBITS - 1);
        end
        DIV: begin
          if (div_hit) rem <= rem - div_d;
          q <= q_next;
          i <= i - 1'b1;
          if (i == '0) begin
            out_data   <= uncorr ? '0 : q_next;
            out_loc    <= uncorr ? '0 : loc;
            out_corr   <= corr;
            out_uncorr <= uncorr;
          end
        end
        DONE: if (out_ready) begin
          out_data   <= '0;
          out_loc    <= '0;
          out_corr   <= 1'b0;
          out_uncorr <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
